// File: rtl/fp32_addsub_seq.sv
// Sequential IEEE-754 binary32 add/sub (RNE, denormals flushed to zero), one operation in flight.
// Latency 5+d+k cycles (2 for special operands); the result is held on out_valid until out_ready.
module fp32_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        add,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sub_q, sub_d;
  logic        sign_q, sign_d;
  logic        eff_sub_q, eff_sub_d;
  logic [9:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [27:0] x_q, x_d;
  logic [27:0] y_q, y_d;
  logic [27:0] sum_q, sum_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  exp_a, exp_b, exp_x, exp_y, exp_diff;
  logic [22:0] frac_a, frac_b, frac_x, frac_y;
  logic        sign_b_eff, eff_sub, swap;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  // Operand classification and magnitude ordering from the captured request.
  always_comb begin
    exp_a      = op_a_q[30:23];
    exp_b      = op_b_q[30:23];
    frac_a     = op_a_q[22:0];
    frac_b     = op_b_q[22:0];
    sign_b_eff = op_b_q[31] ^ sub_q;
    eff_sub    = op_a_q[31] != sign_b_eff;
    nan_a      = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b      = (exp_b == 8'hFF) && (frac_b != 23'd0);
    inf_a      = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b      = (exp_b == 8'hFF) && (frac_b == 23'd0);
    zero_a     = (exp_a == 8'd0);
    zero_b     = (exp_b == 8'd0);
    swap       = op_b_q[30:0] > op_a_q[30:0];
    exp_x      = swap ? exp_b : exp_a;
    exp_y      = swap ? exp_a : exp_b;
    frac_x     = swap ? frac_b : frac_a;
    frac_y     = swap ? frac_a : frac_b;
    exp_diff   = exp_x - exp_y;
  end

  logic        round_up;
  logic [23:0] frac_rnd;
  logic [9:0]  exp_rnd;

  // In ROUND the hidden bit sum_q[26] is always set, so only the fraction is incremented.
  always_comb begin
    round_up = sum_q[2] & (sum_q[3] | sum_q[1] | sum_q[0]);
    frac_rnd = {1'b0, sum_q[25:3]} + {23'd0, round_up};
    exp_rnd  = exp_q + {9'd0, frac_rnd[23]};
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sub_d       = sub_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    sum_d       = sum_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b;
          sub_d   = sub & ~add;
          state_d = PRE;
        end
      end

      PRE: begin
        flags_d = 3'b000;
        state_d = DONE;
        if (nan_a || nan_b) begin
          result_d = QNAN;
          flags_d  = 3'b100;
        end else if (inf_a && inf_b && eff_sub) begin
          result_d = QNAN;
          flags_d  = 3'b100;
        end else if (inf_a) begin
          result_d = {op_a_q[31], 8'hFF, 23'd0};
        end else if (inf_b) begin
          result_d = {sign_b_eff, 8'hFF, 23'd0};
        end else if (zero_a && zero_b) begin
          result_d = {op_a_q[31] & sign_b_eff, 31'd0};
        end else if (zero_a) begin
          result_d = {sign_b_eff, op_b_q[30:0]};
        end else if (zero_b) begin
          result_d = op_a_q;
        end else begin
          sign_d    = swap ? sign_b_eff : op_a_q[31];
          eff_sub_d = eff_sub;
          exp_d     = {2'b00, exp_x};
          x_d       = {2'b01, frac_x, 3'b000};
          y_d       = {2'b01, frac_y, 3'b000};
          cnt_d     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
          state_d   = (exp_diff != 8'd0) ? ALIGN : ADD;
        end
      end

      ALIGN: begin
        y_d   = {1'b0, y_q[27:2], y_q[1] | y_q[0]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ADD;
        end
      end

      ADD: begin
        sum_d   = eff_sub_q ? (x_q - y_q) : (x_q + y_q);
        state_d = NORM;
      end

      NORM: begin
        if (sum_q == 28'd0) begin
          result_d = 32'd0;
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if (sum_q[27]) begin
          sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 10'd1;
          state_d = ROUND;
        end else if (sum_q[26]) begin
          state_d = ROUND;
        end else if (exp_q <= 10'd1) begin
          // Result would be subnormal: flush to a signed zero.
          result_d = {sign_q, 31'd0};
          flags_d  = 3'b001;
          state_d  = DONE;
        end else begin
          sum_d = {sum_q[26:0], 1'b0};
          exp_d = exp_q - 10'd1;
        end
      end

      ROUND: begin
        state_d = DONE;
        if (exp_rnd >= 10'd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 3'b010;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac_rnd[22:0]};
          flags_d  = 3'b000;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      sub_q       <= 1'b0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= 10'd0;
      cnt_q       <= 5'd0;
      x_q         <= 28'd0;
      y_q         <= 28'd0;
      sum_q       <= 28'd0;
      result_q    <= 32'd0;
      flags_q     <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sub_q       <= sub_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
